// File: rtl/video_timing_detector_if.sv
// Pixel stream as seen at the mixer output: pixel enable plus the three VGA
// timing strobes. The mixer drives it, the timing detector listens.
interface video_timing_detector_if;
  logic CE_PIXEL;
  logic VGA_HS;
  logic VGA_VS;
  logic VGA_DE;

  modport master (output CE_PIXEL, VGA_HS, VGA_VS, VGA_DE);
  modport slave  (input  CE_PIXEL, VGA_HS, VGA_VS, VGA_DE);
endinterface

// File: rtl/video_timing_detector.sv
// Measures line/frame geometry and sync polarity of a VGA stream and reports
// the result once it has been identical for STABLE_FRAMES consecutive frames.
module video_timing_detector #(
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT       = 2**22
) (
  input  logic                          CLK_VIDEO,
  input  logic                          RESET_N,
  video_timing_detector_if.slave        vid,
  output logic [CNT_W-1:0]              H_TOTAL,
  output logic [CNT_W-1:0]              H_ACTIVE,
  output logic [CNT_W-1:0]              V_TOTAL,
  output logic [CNT_W-1:0]              V_ACTIVE,
  output logic                          HS_POL,
  output logic                          VS_POL,
  output logic                          LOCKED,
  output logic                          MODE_CHG
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int MC_W  = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  MC_LAST   = MC_W'(STABLE_FRAMES - 1);

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_active;
    logic             hs_pol;
    logic             vs_pol;
  } mode_t;

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             hs_s_reg, vs_s_reg, hs_pol_reg, vs_pol_reg;
  logic [CNT_W-1:0] hcnt_reg, decnt_reg, hhi_reg, h_meas_reg, ha_meas_reg;
  logic [CNT_W-1:0] hcnt_next, decnt_next, hhi_next, h_meas_next, ha_meas_next;
  logic [CNT_W-1:0] lcnt_reg, acnt_reg, vhi_reg, lcnt_next, acnt_next, vhi_next;
  logic             line_pol_h_reg, line_pol_h_next;
  mode_t            cand_now, cand_reg, prev_reg, out_reg;
  logic             cand_valid, pol_same, cand_ok_reg, frame_evt_reg, match;
  logic [TMO_W-1:0] tmo_reg;
  logic             tmo_hit;
  state_t           state_reg, state_next;
  logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;
  logic             load_out, clear_out, mode_chg_reg, mode_chg_next;

  logic hs_lead, vs_lead;
  assign hs_lead = vid.CE_PIXEL && (vid.VGA_HS == hs_pol_reg) && (hs_s_reg != hs_pol_reg);
  assign vs_lead = vid.CE_PIXEL && (vid.VGA_VS == vs_pol_reg) && (vs_s_reg != vs_pol_reg);

  // The pixel at an HS leading edge is the first pixel of the new line, so
  // the line counters restart at that pixel rather than at zero.
  always_comb begin
    hcnt_next       = hcnt_reg;
    decnt_next      = decnt_reg;
    hhi_next        = hhi_reg;
    h_meas_next     = h_meas_reg;
    ha_meas_next    = ha_meas_reg;
    line_pol_h_next = line_pol_h_reg;
    lcnt_next       = lcnt_reg;
    acnt_next       = acnt_reg;
    vhi_next        = vhi_reg;
    if (vid.CE_PIXEL) begin
      if (hs_lead) begin
        h_meas_next = hcnt_reg;
        // Blanking lines carry no active width; keep the last real one.
        if (decnt_reg != '0) begin
          ha_meas_next = decnt_reg;
          acnt_next    = sat_inc(acnt_reg);
        end
        if (hcnt_reg != '0)
          line_pol_h_next = ({hhi_reg, 1'b0} < {1'b0, hcnt_reg});
        lcnt_next  = sat_inc(lcnt_reg);
        if (vs_s_reg)
          vhi_next = sat_inc(vhi_reg);
        hcnt_next  = CNT_W'(1);
        decnt_next = vid.VGA_DE ? CNT_W'(1) : '0;
        hhi_next   = vid.VGA_HS ? CNT_W'(1) : '0;
      end else begin
        hcnt_next = sat_inc(hcnt_reg);
        if (vid.VGA_DE) decnt_next = sat_inc(decnt_reg);
        if (vid.VGA_HS) hhi_next   = sat_inc(hhi_reg);
      end
    end
    cand_now.h_total  = h_meas_next;
    cand_now.h_active = ha_meas_next;
    cand_now.v_total  = lcnt_next;
    cand_now.v_active = acnt_next;
    cand_now.hs_pol   = line_pol_h_next;
    cand_now.vs_pol   = (lcnt_next != '0) ? ({vhi_next, 1'b0} < {1'b0, lcnt_next}) : vs_pol_reg;
    if (vs_lead) begin
      lcnt_next = '0;
      acnt_next = '0;
      vhi_next  = '0;
    end
  end

  assign cand_valid = (cand_now.h_total != CNT_MAX) && (cand_now.h_active != CNT_MAX) &&
                      (cand_now.v_total != CNT_MAX) && (cand_now.v_active != CNT_MAX);
  assign pol_same   = (cand_now.hs_pol == hs_pol_reg) && (cand_now.vs_pol == vs_pol_reg);
  assign match      = cand_ok_reg && (cand_reg == prev_reg);
  assign tmo_hit    = (tmo_reg == TMO_LIMIT);

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_s_reg       <= 1'b0;
      vs_s_reg       <= 1'b0;
      hs_pol_reg     <= 1'b1;
      vs_pol_reg     <= 1'b1;
      line_pol_h_reg <= 1'b1;
      hcnt_reg       <= '0;
      decnt_reg      <= '0;
      hhi_reg        <= '0;
      h_meas_reg     <= '0;
      ha_meas_reg    <= '0;
      lcnt_reg       <= '0;
      acnt_reg       <= '0;
      vhi_reg        <= '0;
      cand_reg       <= '0;
      prev_reg       <= '0;
      cand_ok_reg    <= 1'b0;
      frame_evt_reg  <= 1'b0;
      tmo_reg        <= '0;
    end else begin
      hcnt_reg       <= hcnt_next;
      decnt_reg      <= decnt_next;
      hhi_reg        <= hhi_next;
      h_meas_reg     <= h_meas_next;
      ha_meas_reg    <= ha_meas_next;
      line_pol_h_reg <= line_pol_h_next;
      lcnt_reg       <= lcnt_next;
      acnt_reg       <= acnt_next;
      vhi_reg        <= vhi_next;
      frame_evt_reg  <= vs_lead;
      if (vid.CE_PIXEL) begin
        hs_s_reg <= vid.VGA_HS;
        vs_s_reg <= vid.VGA_VS;
      end
      // A polarity change is adopted immediately but never counts as a match.
      if (vs_lead) begin
        prev_reg    <= cand_reg;
        cand_reg    <= cand_now;
        cand_ok_reg <= cand_valid && pol_same;
        hs_pol_reg  <= cand_now.hs_pol;
        vs_pol_reg  <= cand_now.vs_pol;
      end
      if (vs_lead)
        tmo_reg <= '0;
      else if (!tmo_hit)
        tmo_reg <= tmo_reg + 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    match_cnt_next = match_cnt_reg;
    load_out       = 1'b0;
    clear_out      = 1'b0;
    mode_chg_next  = 1'b0;
    if (tmo_hit) begin
      state_next     = S_SEARCH;
      match_cnt_next = '0;
      clear_out      = 1'b1;
      mode_chg_next  = (state_reg == S_LOCKED);
    end else if (frame_evt_reg) begin
      case (state_reg)
        S_SEARCH: begin
          state_next     = S_MEASURE;
          match_cnt_next = '0;
        end
        S_MEASURE: begin
          if (!match) begin
            match_cnt_next = '0;
          end else if (match_cnt_reg == MC_LAST) begin
            state_next     = S_LOCKED;
            match_cnt_next = '0;
            load_out       = 1'b1;
            mode_chg_next  = 1'b1;
          end else begin
            match_cnt_next = match_cnt_reg + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!match) begin
            state_next     = S_MEASURE;
            match_cnt_next = '0;
            mode_chg_next  = 1'b1;
          end
        end
        default: state_next = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= S_SEARCH;
      match_cnt_reg <= '0;
      mode_chg_reg  <= 1'b0;
      out_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      match_cnt_reg <= match_cnt_next;
      mode_chg_reg  <= mode_chg_next;
      if (clear_out)
        out_reg <= '0;
      else if (load_out)
        out_reg <= cand_reg;
    end
  end

  assign H_TOTAL  = out_reg.h_total;
  assign H_ACTIVE = out_reg.h_active;
  assign V_TOTAL  = out_reg.v_total;
  assign V_ACTIVE = out_reg.v_active;
  assign HS_POL   = out_reg.hs_pol;
  assign VS_POL   = out_reg.vs_pol;
  assign LOCKED   = (state_reg == S_LOCKED);
  assign MODE_CHG = mode_chg_reg;
endmodule

// File: tb/tb_video_timing_detector.sv
// Directed bench: small synthetic video modes driven with CE every second
// clock; lock latency, mode change, timeout, saturation and async reset.
module tb_video_timing_detector;
  localparam int CNT_W  = 8;
  localparam int STABLE = 4;
  localparam int TMO    = 2400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_detector_if vif ();

  logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
  logic             hs_pol, vs_pol, locked, mode_chg;

  video_timing_detector #(.CNT_W(CNT_W), .STABLE_FRAMES(STABLE), .TIMEOUT(TMO)) dut (
    .CLK_VIDEO (clk),
    .RESET_N   (rst_n),
    .vid       (vif),
    .H_TOTAL   (h_total),
    .H_ACTIVE  (h_active),
    .V_TOTAL   (v_total),
    .V_ACTIVE  (v_active),
    .HS_POL    (hs_pol),
    .VS_POL    (vs_pol),
    .LOCKED    (locked),
    .MODE_CHG  (mode_chg)
  );

  int checks = 0;
  int errors = 0;
  int mc_cnt = 0;
  int mc_base;

  always @(negedge clk) if (mode_chg === 1'b1) mc_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic check_outs(input string tag, input int ht, ha, vt, va,
                            input logic hp, vp, lk);
    check({tag, "_h_total"},  32'(h_total),  32'(ht));
    check({tag, "_h_active"}, 32'(h_active), 32'(ha));
    check({tag, "_v_total"},  32'(v_total),  32'(vt));
    check({tag, "_v_active"}, 32'(v_active), 32'(va));
    check({tag, "_hs_pol"},   32'(hs_pol),   32'(hp));
    check({tag, "_vs_pol"},   32'(vs_pol),   32'(vp));
    check({tag, "_locked"},   32'(locked),   32'(lk));
  endtask

  task automatic pix(input logic hs, vs, de);
    @(negedge clk);
    vif.CE_PIXEL = 1'b1;
    vif.VGA_HS   = hs;
    vif.VGA_VS   = vs;
    vif.VGA_DE   = de;
    @(negedge clk);
    vif.CE_PIXEL = 1'b0;
  endtask

  // HS active on pixels 0..2, VS active on lines 0..1, active area bottom-right.
  task automatic send_frame(input int ht, ha, vt, va, input logic hp, vp,
                            input logic hold_hs, hold_vs, input int nlines);
    logic hs_a, vs_a, de;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < ht; x++) begin
        hs_a = hold_hs ? 1'b0 : (x < 3);
        vs_a = hold_vs ? 1'b0 : (y < 2);
        de   = (x >= ht - ha) && (y >= vt - va);
        pix(hp ? hs_a : ~hs_a, vp ? vs_a : ~vs_a, de);
      end
    end
  endtask

  task automatic send_a(input int n);
    for (int i = 0; i < n; i++) send_frame(24, 16, 14, 10, 1'b1, 1'b1, 1'b0, 1'b0, 14);
  endtask

  task automatic send_b(input int n);
    for (int i = 0; i < n; i++) send_frame(30, 20, 16, 12, 1'b1, 1'b1, 1'b0, 1'b0, 16);
  endtask

  // Lock must appear exactly with the n-th frame start and not one frame earlier.
  task automatic relock(input string tag, input int n, input logic mode_b);
    for (int i = 1; i <= n; i++) begin
      if (mode_b) send_b(1); else send_a(1);
      if (i == n - 1) check({tag, "_not_yet_locked"}, 32'(locked), 32'd0);
    end
    if (mode_b) check_outs(tag, 30, 20, 16, 12, 1'b1, 1'b1, 1'b1);
    else        check_outs(tag, 24, 16, 14, 10, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    vif.CE_PIXEL = 1'b0;
    vif.VGA_HS   = 1'b0;
    vif.VGA_VS   = 1'b0;
    vif.VGA_DE   = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("reset_mode_chg", 32'(mode_chg), 32'd0);
    rst_n = 1'b1;

    // Positive-polarity lock after STABLE+2 VS edges.
    mc_base = mc_cnt;
    relock("lock_a", STABLE + 2, 1'b0);
    check("lock_a_mode_chg", 32'(mc_cnt - mc_base), 32'd1);

    // Mode switch: first B frame still closes an A frame.
    mc_base = mc_cnt;
    send_b(1);
    check("modeb_first_locked", 32'(locked), 32'd1);
    send_b(1);
    check("modeb_drop_locked", 32'(locked), 32'd0);
    check("modeb_drop_keeps_htotal", 32'(h_total), 32'd24);
    check("modeb_drop_mode_chg", 32'(mc_cnt - mc_base), 32'd1);
    relock("lock_b", STABLE, 1'b1);
    check("lock_b_mode_chg", 32'(mc_cnt - mc_base), 32'd2);

    // VS stops: lock survives until TIMEOUT clocks after the last edge.
    mc_base = mc_cnt;
    send_frame(30, 20, 16, 12, 1'b1, 1'b1, 1'b0, 1'b1, 16);
    check("tmo_before_locked", 32'(locked), 32'd1);
    repeat (600) @(negedge clk);
    check_outs("tmo_after", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("tmo_mode_chg", 32'(mc_cnt - mc_base), 32'd1);

    // Recover, then a frame with no HS saturates the pixel counter.
    mc_base = mc_cnt;
    relock("relock_tmo", STABLE + 2, 1'b0);
    send_frame(24, 16, 14, 10, 1'b1, 1'b1, 1'b1, 1'b0, 14);
    check("hs_hold_locked", 32'(locked), 32'd0);
    check("hs_hold_keeps_htotal", 32'(h_total), 32'd24);
    relock("relock_sat", STABLE + 2, 1'b0);
    check("sat_mode_chg", 32'(mc_cnt - mc_base), 32'd3);

    // Asynchronous reset in mid-frame while locked.
    mc_base = mc_cnt;
    send_frame(24, 16, 14, 10, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    #3 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check("async_rst_mode_chg", 32'(mode_chg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    relock("relock_rst", STABLE + 2, 1'b0);
    check("rst_mode_chg", 32'(mc_cnt - mc_base), 32'd1);

    // Both syncs inverted: polarity is learnt, counts are unchanged.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mc_base = mc_cnt;
    for (int i = 0; i < 12; i++) begin
      send_frame(24, 16, 14, 10, 1'b0, 1'b0, 1'b0, 1'b0, 14);
      if (locked) break;
    end
    check_outs("neg_pol", 24, 16, 14, 10, 1'b0, 1'b0, 1'b1);
    check("neg_pol_mode_chg", 32'(mc_cnt - mc_base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
